gbsha_fir_inverse: RTL

//  Inverse (decoder) filter for the 2-tap FIR stream y[n] = x[n] + COEF*x[n-1].

---
 rtl/gbsha_fir_inverse_if.sv | 30 +++
 rtl/gbsha_fir_inverse.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/gbsha_fir_inverse_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// gbsha_fir_inverse_if : sample stream and status bundle of the inverse FIR.
// Revision: 1.0
// ---------------------------------------------------------------------------
interface gbsha_fir_inverse_if #(
    parameter int BW_in  = 4,
    parameter int BW_out = 2
);
    logic [BW_in-1:0]  y_in;
    logic              in_valid;
    logic              in_ready;
    logic [BW_out-1:0] x_out;
    logic              out_valid;
    logic              out_ready;
    logic              sat;
    logic              fault;
    logic              clear_err;

    modport master (
        output y_in, in_valid, out_ready, clear_err,
        input  in_ready, x_out, out_valid, sat, fault
    );

    modport slave (
        input  y_in, in_valid, out_ready, clear_err,
        output in_ready, x_out, out_valid, sat, fault
    );
endinterface
`default_nettype wire

// File: rtl/gbsha_fir_inverse.sv
`default_nettype none
// ---------------------------------------------------------------------------
// gbsha_fir_inverse : recovers x[n] = y[n] - COEF*x[n-1] with saturation and FAULT stall.
// Revision: 1.0
// ---------------------------------------------------------------------------
module gbsha_fir_inverse #(
    parameter int BW_in     = 4,
    parameter int BW_out    = 2,
    parameter int COEF      = 2,
    parameter int BW_acc    = 7,
    parameter int SAT_LIMIT = 4
) (
    input  wire logic          clk,
    input  wire logic          reset,
    gbsha_fir_inverse_if.slave bus
);
    localparam int c_cnt_w = $clog2(SAT_LIMIT + 1);
    localparam logic [c_cnt_w-1:0]       c_sat_limit = c_cnt_w'(SAT_LIMIT);
    localparam logic signed [BW_acc-1:0] c_coef      = BW_acc'(COEF);
    localparam logic signed [BW_acc-1:0] c_acc_max   = BW_acc'((2 ** (BW_out - 1)) - 1);
    localparam logic signed [BW_acc-1:0] c_acc_min   = BW_acc'(-(2 ** (BW_out - 1)));
    localparam logic [BW_out-1:0]        c_x_max     = BW_out'((2 ** (BW_out - 1)) - 1);
    localparam logic [BW_out-1:0]        c_x_min     = BW_out'(-(2 ** (BW_out - 1)));

    typedef enum logic [1:0] {
        ST_PRIME = 2'd0,
        ST_RUN   = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [BW_out-1:0]    x_prev_q, x_prev_d;
    logic [c_cnt_w-1:0]   sat_cnt_q, sat_cnt_d;
    logic [BW_out-1:0]    x_out_q, x_out_d;
    logic                 sat_q, sat_d;
    logic                 out_valid_q, out_valid_d;
    logic                 fault_q, fault_d;

    logic                 in_ready;
    logic                 accept;
    logic [BW_out-1:0]    x_hist;
    logic signed [BW_acc-1:0] y_ext, x_ext, prod, acc;
    logic [BW_out-1:0]    x_new;
    logic                 sat_new;
    logic [c_cnt_w-1:0]   sat_cnt_inc;
    logic                 trigger;

    always_comb begin
        // Gated by reset so the block never advertises ready while held in reset.
        in_ready = reset && (state_q != ST_FAULT) && (!out_valid_q || bus.out_ready);
        accept   = bus.in_valid && in_ready;

        x_hist = bus.clear_err ? '0 : x_prev_q;
        y_ext  = {{(BW_acc - BW_in){bus.y_in[BW_in-1]}}, bus.y_in};
        x_ext  = {{(BW_acc - BW_out){x_hist[BW_out-1]}}, x_hist};
        prod   = c_coef * x_ext;
        acc    = y_ext - prod;

        sat_new = 1'b1;
        if (acc > c_acc_max) begin
            x_new = c_x_max;
        end else if (acc < c_acc_min) begin
            x_new = c_x_min;
        end else begin
            x_new   = acc[BW_out-1:0];
            sat_new = 1'b0;
        end

        sat_cnt_inc = sat_cnt_q + 1'b1;
        trigger     = accept && sat_new && (sat_cnt_inc == c_sat_limit);
    end

    always_comb begin
        state_d     = state_q;
        x_prev_d    = x_prev_q;
        sat_cnt_d   = sat_cnt_q;
        x_out_d     = x_out_q;
        sat_d       = sat_q;
        out_valid_d = out_valid_q;
        fault_d     = fault_q;

        if (accept) begin
            x_out_d     = x_new;
            sat_d       = sat_new;
            out_valid_d = 1'b1;
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            ST_PRIME, ST_RUN: begin
                if (accept) begin
                    x_prev_d  = x_new;
                    sat_cnt_d = sat_new ? sat_cnt_inc : '0;
                    state_d   = ST_RUN;
                    if (trigger) begin
                        state_d = ST_FAULT;
                        fault_d = 1'b1;
                    end
                end
                // A clear overrides FAULT entry; otherwise a same-cycle accept seeds the history.
                if (bus.clear_err) begin
                    sat_cnt_d = '0;
                    if (!accept || trigger) begin
                        state_d  = ST_PRIME;
                        x_prev_d = '0;
                        fault_d  = 1'b0;
                    end
                end
            end
            ST_FAULT: begin
                if (bus.clear_err) begin
                    state_d   = ST_PRIME;
                    x_prev_d  = '0;
                    sat_cnt_d = '0;
                    fault_d   = 1'b0;
                end
            end
            default: state_d = ST_PRIME;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_PRIME;
            x_prev_q    <= '0;
            sat_cnt_q   <= '0;
            x_out_q     <= '0;
            sat_q       <= 1'b0;
            out_valid_q <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_prev_q    <= x_prev_d;
            sat_cnt_q   <= sat_cnt_d;
            x_out_q     <= x_out_d;
            sat_q       <= sat_d;
            out_valid_q <= out_valid_d;
            fault_q     <= fault_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.x_out     = x_out_q;
    assign bus.out_valid = out_valid_q;
    assign bus.sat       = sat_q;
    assign bus.fault     = fault_q;
endmodule
`default_nettype wire
